pipelined_adder: RTL and testbench

//   Parametrised, pipelined two's-complement add/subtract unit with valid/ready handshakes.
//   The carry chain is split into STAGES equal segments, one register stage each, so wide adds close timing.

---
 rtl/pipelined_adder.sv | 163 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Two's-complement add/subtract unit whose carry chain is cut into STAGES
//   equal segments of SEG = WIDTH/STAGES bits, with one register per segment.
//   Stage k adds operand segment k using the carry registered by stage k-1.
//   Finished low segments of the sum and unused high segments of the operands
//   travel skewed through the pipeline alongside it.
//   A single advance signal moves every stage at once, so bubbles keep their
//   position and results leave in acceptance order.
//
// Ports
//   clk, rst           clock (rising edge); asynchronous active-high reset
//   in_valid/in_ready  operand beat handshake
//   in_a, in_b         operands, WIDTH bits
//   in_cin             carry in; only used in add mode
//   in_sub             1: A - B, 0: A + B + cin
//   out_valid/out_ready result beat handshake
//   out_sum            result modulo 2^WIDTH
//   out_cout           carry out of the MSB (subtract: 1 means no borrow)
//   out_ovf            signed overflow
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG         = WIDTH / SAFE_STAGES;
  localparam int LAST        = SAFE_STAGES - 1;

  // Reject parameter sets that cannot be split into equal carry segments.
  generate
    if (WIDTH < 1 || STAGES < 1 || (WIDTH % SAFE_STAGES) != 0) begin : g_bad_params
      $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES >= 1");
    end
  endgenerate

  logic                   adv;
  logic [WIDTH-1:0]       b_eff;
  logic                   c0;

  logic [SAFE_STAGES-1:0] valid_q, valid_d;
  logic [SAFE_STAGES-1:0] carry_q, carry_d;
  logic                   ovf_q,   ovf_d;
  logic [WIDTH-1:0]       a_q   [SAFE_STAGES];
  logic [WIDTH-1:0]       a_d   [SAFE_STAGES];
  logic [WIDTH-1:0]       b_q   [SAFE_STAGES];
  logic [WIDTH-1:0]       b_d   [SAFE_STAGES];
  logic [WIDTH-1:0]       sum_q [SAFE_STAGES];
  logic [WIDTH-1:0]       sum_d [SAFE_STAGES];

  // What each stage sees at its input: the port operands for stage 0,
  // the previous stage register otherwise.
  logic [SAFE_STAGES-1:0] src_valid;
  logic [SAFE_STAGES-1:0] src_carry;
  logic [WIDTH-1:0]       src_a   [SAFE_STAGES];
  logic [WIDTH-1:0]       src_b   [SAFE_STAGES];
  logic [WIDTH-1:0]       src_sum [SAFE_STAGES];

  // Subtraction is A + ~B + 1; in_cin is deliberately ignored in that mode.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0    = in_sub ? 1'b1 : in_cin;

  // The whole pipe moves unless a finished result is waiting on the consumer.
  // in_ready therefore depends only on registered state and out_ready.
  assign adv      = !valid_q[LAST] || out_ready;
  assign in_ready = adv;

  genvar k;
  generate
    for (k = 0; k < SAFE_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign src_valid[k] = in_valid;
        assign src_carry[k] = c0;
        assign src_a[k]     = in_a;
        assign src_b[k]     = b_eff;
        assign src_sum[k]   = '0;
      end else begin : g_next
        assign src_valid[k] = valid_q[k-1];
        assign src_carry[k] = carry_q[k-1];
        assign src_a[k]     = a_q[k-1];
        assign src_b[k]     = b_q[k-1];
        assign src_sum[k]   = sum_q[k-1];
      end

      // Low operand segments of a stage register are already consumed and the
      // last stage only needs its sum, carry and overflow.
      logic unused_operands;
      assign unused_operands = ^{a_q[k], b_q[k]};
    end
  endgenerate

  // Each stage resolves its own segment and copies everything else forward.
  // Overflow is resolved while loading the last stage so the output port is
  // a plain register.
  always_comb begin : comb_stages
    logic [SEG:0] seg_res;
    seg_res = '0;
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < SAFE_STAGES; i++) begin
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
      sum_d[i] = sum_q[i];
    end
    if (adv) begin
      for (int i = 0; i < SAFE_STAGES; i++) begin
        seg_res = {1'b0, src_a[i][i*SEG +: SEG]}
                + {1'b0, src_b[i][i*SEG +: SEG]}
                + {{SEG{1'b0}}, src_carry[i]};
        valid_d[i]                = src_valid[i];
        carry_d[i]                = seg_res[SEG];
        a_d[i]                    = src_a[i];
        b_d[i]                    = src_b[i];
        sum_d[i]                  = src_sum[i];
        sum_d[i][i*SEG +: SEG]    = seg_res[SEG-1:0];
      end
      ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
              (sum_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < SAFE_STAGES; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < SAFE_STAGES; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        sum_q[i] <= sum_d[i];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = carry_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Bench for pipelined_adder: an 8-bit/2-stage instance for directed and
//   streaming scenarios and a 32-bit/4-stage instance for a long random run.
//   Expected results come from an arithmetic reference model.
module tb_pipelined_adder;

  localparam int N_WIDE = 10000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // 8-bit, 2-stage instance
  logic       s_in_valid = 1'b0, s_in_ready;
  logic [7:0] s_in_a = '0, s_in_b = '0;
  logic       s_in_cin = 1'b0, s_in_sub = 1'b0;
  logic       s_out_valid, s_out_ready = 1'b1;
  logic [7:0] s_out_sum;
  logic       s_out_cout, s_out_ovf;

  // 32-bit, 4-stage instance
  logic        w_in_valid = 1'b0, w_in_ready;
  logic [31:0] w_in_a = '0, w_in_b = '0;
  logic        w_in_cin = 1'b0, w_in_sub = 1'b0;
  logic        w_out_valid, w_out_ready = 1'b1;
  logic [31:0] w_out_sum;
  logic        w_out_cout, w_out_ovf;

  int total = 0;
  int bad   = 0;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin), .in_sub(s_in_sub),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut_wide (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_cin(w_in_cin), .in_sub(w_in_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_sum(w_out_sum), .out_cout(w_out_cout), .out_ovf(w_out_ovf)
  );

  // Returns {cout, ovf, sum[31:0]} for a w-bit add or subtract, using plain
  // integer arithmetic on unsigned and signed interpretations of the operands.
  function automatic logic [33:0] ref_model(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit cin,
                                            input bit sub);
    longint unsigned mask, full;
    longint          sa, sb, sres, smax, smin;
    logic            cout, ovf;
    mask = (64'd1 << w) - 64'd1;
    sa = longint'(a);
    sb = longint'(b);
    if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
    if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    if (sub) begin
      cout = (a >= b);
      full = (a - b) & mask;
      sres = sa - sb;
    end else begin
      full = a + b + 64'(cin);
      cout = ((full >> w) & 64'd1) != 0;
      full = full & mask;
      sres = sa + sb + longint'(cin);
    end
    ovf = (sres > smax) || (sres < smin);
    return {cout, ovf, full[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Offers one beat to the small instance and waits for its result.
  // lat is the number of cycles from the accepting edge to out_valid, -1 on timeout.
  task automatic apply_beat_small(input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub,
                                  output logic [7:0] sum, output logic cout,
                                  output logic ovf, output int lat);
    lat  = -1;
    sum  = 'x;
    cout = 1'bx;
    ovf  = 1'bx;
    @(negedge clk);
    s_in_a = a; s_in_b = b; s_in_cin = cin; s_in_sub = sub;
    s_in_valid  = 1'b1;
    s_out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      s_in_valid = 1'b0;
      #1;
      if (s_out_valid) begin
        lat = i; sum = s_out_sum; cout = s_out_cout; ovf = s_out_ovf;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({s_out_valid, s_out_sum, s_out_cout, s_out_ovf} !== 11'h0) begin
      bad++;
      $display("[TB] FAIL reset_small_outputs got=%h want=000", {s_out_valid, s_out_sum, s_out_cout, s_out_ovf});
    end
    total++;
    if ({w_out_valid, w_out_sum, w_out_cout, w_out_ovf} !== 35'h0) begin
      bad++;
      $display("[TB] FAIL reset_wide_outputs got=%h want=0", {w_out_valid, w_out_sum, w_out_cout, w_out_ovf});
    end
    total++;
    if ({s_in_ready, w_in_ready} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL reset_in_ready got=%b want=11", {s_in_ready, w_in_ready});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [7:0] sum; logic cout, ovf; int lat;
    apply_beat_small(8'hFF, 8'h01, 1'b0, 1'b0, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("[TB] FAIL wrap_ff_plus_01 got={%b,%b,%h} want={1,0,00}", cout, ovf, sum);
    end
    total++;
    if (lat !== 2) begin
      bad++;
      $display("[TB] FAIL latency got=%0d want=2", lat);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] sum; logic cout, ovf; int lat;
    apply_beat_small(8'h7F, 8'h01, 1'b0, 1'b0, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b0, 1'b1, 8'h80}) begin
      bad++;
      $display("[TB] FAIL add_7f_01 got={%b,%b,%h} want={0,1,80}", cout, ovf, sum);
    end
    apply_beat_small(8'h80, 8'hFF, 1'b0, 1'b0, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b1, 1'b1, 8'h7F}) begin
      bad++;
      $display("[TB] FAIL add_80_ff got={%b,%b,%h} want={1,1,7f}", cout, ovf, sum);
    end
    apply_beat_small(8'h10, 8'h20, 1'b1, 1'b0, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'h31}) begin
      bad++;
      $display("[TB] FAIL add_cin got={%b,%b,%h} want={0,0,31}", cout, ovf, sum);
    end
  endtask

  task automatic test_sub;
    logic [7:0] sum; logic cout, ovf; int lat;
    apply_beat_small(8'h05, 8'h07, 1'b0, 1'b1, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'hFE}) begin
      bad++;
      $display("[TB] FAIL sub_05_07 got={%b,%b,%h} want={0,0,fe}", cout, ovf, sum);
    end
    apply_beat_small(8'h05, 8'h07, 1'b1, 1'b1, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'hFE}) begin
      bad++;
      $display("[TB] FAIL sub_cin_ignored got={%b,%b,%h} want={0,0,fe}", cout, ovf, sum);
    end
    apply_beat_small(8'h80, 8'h01, 1'b0, 1'b1, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum} !== {1'b1, 1'b1, 8'h7F}) begin
      bad++;
      $display("[TB] FAIL sub_80_01 got={%b,%b,%h} want={1,1,7f}", cout, ovf, sum);
    end
  endtask

  // Streams n random beats into the small instance with in_valid held high.
  // out_ready drops for stall_len cycles starting at cycle stall_at.
  task automatic stream_small(input int n, input int stall_at, input int stall_len,
                              input bit gapless);
    logic [9:0]  exp_q[$];
    logic [9:0]  exp_v;
    logic [10:0] held_vals;
    logic [33:0] r;
    bit held = 1'b0, need_new = 1'b1;
    int cyc = 0, sent = 0, got = 0, first = -1, last = -1;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      s_out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < n) begin
        if (need_new) begin
          s_in_valid = 1'b1;
          s_in_a = 8'($urandom); s_in_b = 8'($urandom);
          s_in_cin = 1'($urandom_range(0, 1)); s_in_sub = 1'($urandom_range(0, 1));
        end
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      if (held) begin
        total++;
        if ({s_out_valid, s_out_sum, s_out_cout, s_out_ovf} !== held_vals) begin
          bad++;
          $display("[TB] FAIL output_hold got=%h want=%h", {s_out_valid, s_out_sum, s_out_cout, s_out_ovf}, held_vals);
        end
      end
      if (s_out_valid && !s_out_ready) begin
        total++;
        if (s_in_ready !== 1'b0) begin
          bad++;
          $display("[TB] FAIL stall_in_ready got=%b want=0", s_in_ready);
        end
      end
      if (s_out_valid && s_out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL stream_extra_result got=%h want=none", s_out_sum);
        end else begin
          exp_v = exp_q.pop_front();
          if ({s_out_cout, s_out_ovf, s_out_sum} !== exp_v) begin
            bad++;
            $display("[TB] FAIL stream_result got=%h want=%h", {s_out_cout, s_out_ovf, s_out_sum}, exp_v);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      held      = s_out_valid && !s_out_ready;
      held_vals = {s_out_valid, s_out_sum, s_out_cout, s_out_ovf};
      if (s_in_valid && s_in_ready) begin
        r = ref_model(8, s_in_a, s_in_b, s_in_cin, s_in_sub);
        exp_q.push_back({r[33], r[32], r[7:0]});
        sent++;
        need_new = 1'b1;
      end else begin
        need_new = !s_in_valid;
      end
    end
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    total++;
    if (got != n || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL stream_count got=%0d want=%0d", got, n);
    end
    if (gapless) begin
      total++;
      if (last - first != n - 1) begin
        bad++;
        $display("[TB] FAIL stream_throughput got_span=%0d want_span=%0d", last - first, n - 1);
      end
    end
  endtask

  task automatic test_back_to_back;
    stream_small(20, 0, 0, 1'b1);
  endtask

  task automatic test_stall;
    stream_small(16, 8, 3, 1'b0);
  endtask

  task automatic test_async_reset;
    logic [7:0] sum; logic cout, ovf; int lat; int stale = 0;
    @(negedge clk);
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_a = 8'h11; s_in_b = 8'h22; s_in_cin = 1'b0; s_in_sub = 1'b0;
    @(negedge clk);
    s_in_a = 8'h33; s_in_b = 8'h44;
    @(negedge clk);
    s_in_valid = 1'b0;
    #1;
    total++;
    if (s_out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_valid got=%b want=1", s_out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({s_out_valid, s_out_sum, s_out_cout, s_out_ovf} !== 11'h0) begin
      bad++;
      $display("[TB] FAIL async_reset_outputs got=%h want=000", {s_out_valid, s_out_sum, s_out_cout, s_out_ovf});
    end
    total++;
    if (s_in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_reset_in_ready got=%b want=1", s_in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (s_out_valid) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("[TB] FAIL stale_after_reset got=%0d want=0", stale);
    end
    apply_beat_small(8'h12, 8'h34, 1'b0, 1'b0, sum, cout, ovf, lat);
    total++;
    if ({cout, ovf, sum, lat} !== {1'b0, 1'b0, 8'h46, 32'd2}) begin
      bad++;
      $display("[TB] FAIL post_reset_beat got={%b,%b,%h,lat %0d} want={0,0,46,lat 2}", cout, ovf, sum, lat);
    end
  endtask

  task automatic test_random_wide;
    logic [33:0] wq[$];
    logic [33:0] exp_v;
    int sent = 0, got = 0, cyc = 0;
    bit pending = 1'b0;
    while (got < N_WIDE && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      w_out_ready = ($urandom_range(0, 9) < 8);
      if (!pending) begin
        if (sent < N_WIDE && $urandom_range(0, 3) != 0) begin
          w_in_valid = 1'b1;
          w_in_a = pick_operand(); w_in_b = pick_operand();
          w_in_cin = 1'($urandom_range(0, 1)); w_in_sub = 1'($urandom_range(0, 1));
        end else begin
          w_in_valid = 1'b0;
        end
      end
      #1;
      if (w_out_valid && w_out_ready) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("[TB] FAIL wide_extra_result got=%h want=none", w_out_sum);
        end else begin
          exp_v = wq.pop_front();
          if ({w_out_cout, w_out_ovf, w_out_sum} !== exp_v) begin
            bad++;
            $display("[TB] FAIL wide_result got=%h want=%h", {w_out_cout, w_out_ovf, w_out_sum}, exp_v);
          end
        end
        got++;
      end
      if (w_in_valid && w_in_ready) begin
        wq.push_back(ref_model(32, w_in_a, w_in_b, w_in_cin, w_in_sub));
        sent++;
        pending = 1'b0;
      end else begin
        pending = w_in_valid;
      end
    end
    w_in_valid  = 1'b0;
    w_out_ready = 1'b1;
    total++;
    if (got != N_WIDE) begin
      bad++;
      $display("[TB] FAIL wide_count got=%0d want=%0d", got, N_WIDE);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_random_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
